// File: rtl/soc_onchip_mem_dp_if.sv
// Avalon-MM slave port bundle for soc_onchip_mem_dp: one instance per port.
interface soc_onchip_mem_dp_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/soc_onchip_mem_dp.sv
// True-dual-port on-chip RAM, two Avalon-MM slaves on one clock, with byte enables,
// 1- or 2-cycle read latency, s1-wins write arbitration and a collision counter.
module soc_onchip_mem_dp #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 342,
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       INIT_FILE    = "soc_onchip_mem_dp.hex"
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clken,
  soc_onchip_mem_dp_if.slave         s1,
  soc_onchip_mem_dp_if.slave         s2,
  output logic [15:0]                collision_count
);

  localparam int unsigned NB = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] addr    [2];
  logic [NB-1:0]         be      [2];
  logic [NB-1:0]         be_eff  [2];
  logic [DATA_WIDTH-1:0] wdata   [2];
  logic [DATA_WIDTH-1:0] rd_word [2];
  logic [1:0]            cs, rd, wr;
  logic [1:0]            inrange, wr_acc, rd_acc;
  logic                  collide;

  (* ram_init_file = INIT_FILE *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_comb begin
    addr[0]  = s1.address;    addr[1]  = s2.address;
    be[0]    = s1.byteenable; be[1]    = s2.byteenable;
    wdata[0] = s1.writedata;  wdata[1] = s2.writedata;
    cs       = {s2.chipselect, s1.chipselect};
    rd       = {s2.read, s1.read};
    wr       = {s2.write, s1.write};
  end

  always_comb begin
    inrange = '0;
    wr_acc  = '0;
    rd_acc  = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      inrange[p] = 32'(addr[p]) < DEPTH;
      wr_acc[p]  = clken & ~reset & cs[p] & wr[p];
      rd_acc[p]  = clken & ~reset & cs[p] & rd[p] & ~wr[p];
    end
  end

  // On a same-address write/write, s2 keeps only the lanes s1 leaves untouched.
  always_comb begin
    collide   = wr_acc[0] & wr_acc[1] & inrange[0] & inrange[1] & (addr[0] == addr[1]);
    be_eff[0] = be[0];
    be_eff[1] = be[1] & ~(collide ? be[0] : '0);
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < 2; p++) begin
      if (wr_acc[p] && inrange[p]) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (be_eff[p][b]) mem[addr[p]][8*b +: 8] <= wdata[p][8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rd_word[p] = inrange[p] ? mem[addr[p]] : '0;
    end
  end

  logic [1:0]            vld1;
  logic [DATA_WIDTH-1:0] dat1 [2];
  logic [1:0]            vld_o;
  logic [DATA_WIDTH-1:0] dat_o [2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld1 <= '0;
      for (int unsigned p = 0; p < 2; p++) dat1[p] <= '0;
    end else if (clken) begin
      vld1 <= rd_acc;
      for (int unsigned p = 0; p < 2; p++) begin
        if (rd_acc[p]) dat1[p] <= rd_word[p];
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [1:0]            vld2;
    logic [DATA_WIDTH-1:0] dat2 [2];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld2 <= '0;
        for (int unsigned p = 0; p < 2; p++) dat2[p] <= '0;
      end else if (clken) begin
        vld2 <= vld1;
        for (int unsigned p = 0; p < 2; p++) begin
          if (vld1[p]) dat2[p] <= dat1[p];
        end
      end
    end

    always_comb begin
      vld_o = vld2;
      for (int unsigned p = 0; p < 2; p++) dat_o[p] = dat2[p];
    end
  end else begin : g_lat1
    always_comb begin
      vld_o = vld1;
      for (int unsigned p = 0; p < 2; p++) dat_o[p] = dat1[p];
    end
  end

  // A beat stalled by clken stays in its register and is presented once clken returns.
  assign s1.readdata      = dat_o[0];
  assign s2.readdata      = dat_o[1];
  assign s1.readdatavalid = vld_o[0] & clken;
  assign s2.readdatavalid = vld_o[1] & clken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      collision_count <= '0;
    end else if (collide && collision_count != '1) begin
      collision_count <= collision_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_soc_onchip_mem_dp.sv
// Directed bench for soc_onchip_mem_dp: latency-1 instance (ports a1/a2) and
// latency-2 instance (ports b1/b2) sharing clock and reset.
module tb_soc_onchip_mem_dp;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clken1 = 1'b1;
  logic        clken2 = 1'b1;
  logic [15:0] cc1, cc2;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  soc_onchip_mem_dp_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) a1 ();
  soc_onchip_mem_dp_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) a2 ();
  soc_onchip_mem_dp_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) b1 ();
  soc_onchip_mem_dp_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) b2 ();

  soc_onchip_mem_dp #(
    .DATA_WIDTH(32), .DEPTH(342), .ADDR_WIDTH(9), .READ_LATENCY(1), .INIT_FILE("")
  ) u_dut1 (
    .clk(clk), .reset(reset), .clken(clken1), .s1(a1), .s2(a2), .collision_count(cc1)
  );

  soc_onchip_mem_dp #(
    .DATA_WIDTH(32), .DEPTH(342), .ADDR_WIDTH(9), .READ_LATENCY(2), .INIT_FILE("")
  ) u_dut2 (
    .clk(clk), .reset(reset), .clken(clken2), .s1(b1), .s2(b2), .collision_count(cc2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // p: 0=a1 1=a2 2=b1 3=b2
  task automatic drv(input int p, input logic r, input logic w, input logic [8:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    case (p)
      0: begin a1.chipselect = r | w; a1.read = r; a1.write = w; a1.address = a;
               a1.writedata = d; a1.byteenable = be; end
      1: begin a2.chipselect = r | w; a2.read = r; a2.write = w; a2.address = a;
               a2.writedata = d; a2.byteenable = be; end
      2: begin b1.chipselect = r | w; b1.read = r; b1.write = w; b1.address = a;
               b1.writedata = d; b1.byteenable = be; end
      default: begin b2.chipselect = r | w; b2.read = r; b2.write = w; b2.address = a;
               b2.writedata = d; b2.byteenable = be; end
    endcase
  endtask

  task automatic idle_all();
    for (int p = 0; p < 4; p++) drv(p, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    idle_all();
    #2 reset = 1'b1;
    #2;
    chk("rst_a1_data", a1.readdata, 32'h0);
    chk("rst_a1_vld", {31'b0, a1.readdatavalid}, 32'h0);
    chk("rst_a2_data", a2.readdata, 32'h0);
    chk("rst_a2_vld", {31'b0, a2.readdatavalid}, 32'h0);
    chk("rst_b1_vld", {31'b0, b1.readdatavalid}, 32'h0);
    chk("rst_cc", {16'b0, cc1}, 32'h0);
    step(); step();
    reset = 1'b0;

    // basic write then cross-port read
    drv(0, 0, 1, 9'd5, 32'hDEADBEEF, 4'hF); step();
    idle_all(); drv(1, 1, 0, 9'd5, '0, '0); step();
    idle_all();
    chk("basic_vld", {31'b0, a2.readdatavalid}, 32'h1);
    chk("basic_data", a2.readdata, 32'hDEADBEEF);
    chk("basic_a1_novld", {31'b0, a1.readdatavalid}, 32'h0);
    step();
    chk("basic_strobe_drop", {31'b0, a2.readdatavalid}, 32'h0);

    // byte enables
    drv(0, 0, 1, 9'd7, 32'h11223344, 4'hF); step();
    drv(0, 0, 1, 9'd7, 32'hAABBCCDD, 4'b0101); step();
    drv(0, 1, 0, 9'd7, '0, '0); step();
    idle_all();
    chk("be_vld", {31'b0, a1.readdatavalid}, 32'h1);
    chk("be_data", a1.readdata, 32'h11BB33DD);
    drv(1, 0, 1, 9'd7, 32'hFFFFFFFF, 4'b0000); step();
    drv(1, 1, 0, 9'd7, '0, '0); step();
    idle_all();
    chk("be_zero_noop", a2.readdata, 32'h11BB33DD);

    // same-address write collision
    drv(0, 0, 1, 9'd3, 32'h0, 4'hF); step();
    drv(0, 0, 1, 9'd3, 32'h000000FF, 4'b0001);
    drv(1, 0, 1, 9'd3, 32'h0000FF00, 4'b0011); step();
    idle_all();
    chk("coll_count1", {16'b0, cc1}, 32'h1);
    drv(0, 1, 0, 9'd3, '0, '0); step();
    idle_all();
    chk("coll_data", a1.readdata, 32'h0000FFFF);
    drv(0, 0, 1, 9'd400, 32'h1, 4'hF);
    drv(1, 0, 1, 9'd400, 32'h2, 4'hF); step();
    idle_all();
    chk("coll_oor_nocount", {16'b0, cc1}, 32'h1);

    // cross-port read during write returns old data
    drv(0, 0, 1, 9'd9, 32'h1, 4'hF); step();
    drv(0, 0, 1, 9'd9, 32'h2, 4'hF);
    drv(1, 1, 0, 9'd9, '0, '0); step();
    idle_all();
    chk("rdw_old", a2.readdata, 32'h1);
    chk("rdw_old_vld", {31'b0, a2.readdatavalid}, 32'h1);
    drv(1, 1, 0, 9'd9, '0, '0); step();
    idle_all();
    chk("rdw_new", a2.readdata, 32'h2);

    // read+write on one port: write only, no beat
    drv(0, 1, 1, 9'd10, 32'hA5, 4'hF); step();
    idle_all();
    chk("rw_same_port_novld", {31'b0, a1.readdatavalid}, 32'h0);
    drv(1, 1, 0, 9'd10, '0, '0); step();
    idle_all();
    chk("rw_same_port_data", a2.readdata, 32'hA5);

    // out-of-range write discarded, read beat carries 0
    drv(0, 0, 1, 9'd342, 32'h55, 4'hF); step();
    drv(0, 1, 0, 9'd342, '0, '0); step();
    idle_all();
    chk("oor_vld", {31'b0, a1.readdatavalid}, 32'h1);
    chk("oor_data", a1.readdata, 32'h0);
    drv(0, 1, 0, 9'd86, '0, '0); step();
    idle_all();
    chk("oor_no_alias_vld", {31'b0, a1.readdatavalid}, 32'h1);
    drv(0, 1, 0, 9'd5, '0, '0); step();
    idle_all();
    chk("oor_mem_intact", a1.readdata, 32'hDEADBEEF);

    // latency 2 instance
    drv(2, 0, 1, 9'd0, 32'h100, 4'hF); step();
    drv(2, 0, 1, 9'd1, 32'h101, 4'hF); step();
    drv(2, 0, 1, 9'd2, 32'h102, 4'hF); step();
    drv(2, 1, 0, 9'd0, '0, '0); step();
    idle_all();
    chk("lat2_not_yet", {31'b0, b1.readdatavalid}, 32'h0);
    step();
    chk("lat2_vld", {31'b0, b1.readdatavalid}, 32'h1);
    chk("lat2_data", b1.readdata, 32'h100);
    step();
    chk("lat2_drop", {31'b0, b1.readdatavalid}, 32'h0);

    // latency 2 with a 3-cycle clken stall after the second request
    drv(2, 1, 0, 9'd0, '0, '0); step();
    drv(2, 1, 0, 9'd1, '0, '0); step();
    clken2 = 1'b0;
    drv(2, 0, 1, 9'd2, 32'hBAD, 4'hF);
    #1;
    chk("stall_gated0", {31'b0, b1.readdatavalid}, 32'h0);
    step();
    chk("stall_gated1", {31'b0, b1.readdatavalid}, 32'h0);
    step();
    chk("stall_gated2", {31'b0, b1.readdatavalid}, 32'h0);
    step();
    clken2 = 1'b1;
    drv(2, 1, 0, 9'd2, '0, '0);
    #1;
    chk("stall_beat0_vld", {31'b0, b1.readdatavalid}, 32'h1);
    chk("stall_beat0_data", b1.readdata, 32'h100);
    step();
    idle_all();
    chk("stall_beat1_vld", {31'b0, b1.readdatavalid}, 32'h1);
    chk("stall_beat1_data", b1.readdata, 32'h101);
    step();
    chk("stall_beat2_vld", {31'b0, b1.readdatavalid}, 32'h1);
    chk("stall_beat2_data", b1.readdata, 32'h102);
    step();
    chk("stall_no_extra", {31'b0, b1.readdatavalid}, 32'h0);

    // reset with a read in flight on the latency 2 instance
    drv(2, 1, 0, 9'd1, '0, '0); step();
    idle_all();
    reset = 1'b1;
    #1;
    chk("rst_mid_b1_vld", {31'b0, b1.readdatavalid}, 32'h0);
    chk("rst_mid_b1_data", b1.readdata, 32'h0);
    chk("rst_mid_a1_data", a1.readdata, 32'h0);
    chk("rst_mid_cc", {16'b0, cc1}, 32'h0);
    step();
    reset = 1'b0;
    step();
    chk("rst_dropped0", {31'b0, b1.readdatavalid}, 32'h0);
    step();
    chk("rst_dropped1", {31'b0, b1.readdatavalid}, 32'h0);
    drv(1, 1, 0, 9'd5, '0, '0);
    drv(3, 1, 0, 9'd1, '0, '0); step();
    idle_all();
    chk("rst_mem_kept_a", a2.readdata, 32'hDEADBEEF);
    step();
    chk("rst_mem_kept_b", b2.readdata, 32'h101);

    // collision counter saturation (disjoint masks still count)
    drv(0, 0, 1, 9'd3, 32'h0, 4'b0001);
    drv(1, 0, 1, 9'd3, 32'h0, 4'b0010);
    for (int i = 0; i < 65534; i++) step();
    chk("sat_fffe", {16'b0, cc1}, 32'hFFFE);
    step();
    chk("sat_ffff", {16'b0, cc1}, 32'hFFFF);
    step();
    chk("sat_hold", {16'b0, cc1}, 32'hFFFF);
    idle_all();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/soc_onchip_mem_dp.md
# soc_onchip_mem_dp

Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slave ports (s1, s2). It replaces the fixed 32-bit single-port data memory in the SoC and is instantiated per processor tile as shared data or mailbox memory. It adds configurable width, depth and read latency, `readdatavalid` pipelining, same-address write arbitration, out-of-range protection and a collision counter.

## Interface
- `DATA_WIDTH`, 32: word width; must be a multiple of 8.
- `DEPTH`, 342: number of words; need not be a power of two.
- `ADDR_WIDTH`, 9: address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- `READ_LATENCY`, 1: cycles from an accepted read to `readdatavalid`; legal values are 1 or 2 (2 adds an output register).
- `INIT_FILE`, "soc_onchip_mem_dp.hex": initial contents, loaded at configuration only.
- `clk` in 1: single clock for both ports.
- `reset` in 1: asynchronous, active-high.
- `clken` in 1: global clock enable; low freezes all state.
- `sN_address` in ADDR_WIDTH: word address, for N = 1, 2.
- `sN_chipselect` in 1: port select.
- `sN_read` in 1: read request.
- `sN_write` in 1: write request.
- `sN_byteenable` in DATA_WIDTH/8: byte lane mask for writes.
- `sN_writedata` in DATA_WIDTH: write data.
- `sN_readdata` out DATA_WIDTH: read data, valid only when `sN_readdatavalid` is high.
- `sN_readdatavalid` out 1: single-cycle strobe per completed read.
- `collision_count` out 16: saturating count of same-cycle, same-address write collisions.

## Operation
- Accept conditions, evaluated per port on a cycle with `clken`=1:
  - A write is accepted when `chipselect & write`.
  - A read is accepted when `chipselect & read & ~write`. If `read` and `write` are both high, only the write happens and no read beat is produced.
- Writes update only the byte lanes whose `byteenable` bit is set. `byteenable`=0 is a legal no-op.
- Out-of-range accesses (`address >= DEPTH`):
  - Writes are discarded.
  - Reads still produce a beat, with `readdata` = 0.
- Read-during-write on the same port cannot occur, because read and write are exclusive per cycle.
- Cross-port read/write: if port A reads the address that port B writes in the same cycle, port A returns the old data.
- Cross-port write/write: if both ports write the same in-range address in the same cycle:
  - Port s1's enabled bytes win.
  - Bytes enabled only by s2 are still written.
  - `collision_count` increments by 1 and saturates at 0xFFFF. It increments even if the byte masks are disjoint.
- Read pipeline: per port, a valid bit and a data register per latency stage. With `READ_LATENCY`=2 an output register stage is added. There is no backpressure; the ports accept one request per clock.
- `clken`=0 behaviour:
  - No writes occur and no requests are accepted.
  - All pipeline registers and `collision_count` hold their values.
  - `sN_readdatavalid` is gated low, and a pending beat is presented on the first cycle `clken` returns high. Every beat is delivered exactly once.
- Reset behaviour:
  - Clears all valid bits, `readdata` registers (to 0) and `collision_count`.
  - Reads in flight are dropped with no beat.
  - RAM contents are not reset.

## Timing
- Reset values: `sN_readdata` = 0, `sN_readdatavalid` = 0, `collision_count` = 0.
- A read accepted at edge k gives `readdatavalid`=1 and data on the cycle after edge k+READ_LATENCY-1. With latency 1, the data is visible in the cycle following the request.
- Write data is visible to a read from either port accepted on the next edge or later.
- Throughput is one read or write per port per cycle, sustained. Back-to-back reads return in order, one beat per cycle.
- `reset` asserted mid-stream forces all outputs to their reset values immediately, without waiting for a clock edge. The first request after deassertion is accepted normally on the next `clk` edge with `clken`=1.

## Test plan
- **Basic write/read, READ_LATENCY=1:**
  - Stimulus: s1 writes 0xDEADBEEF to address 5; s2 reads address 5 on the next cycle.
  - Response: s2 `readdatavalid` is high one cycle later with 0xDEADBEEF.
- **Byte enables:**
  - Stimulus: address 7 holds 0x11223344; s1 writes 0xAABBCCDD with byteenable=4'b0101.
  - Response: a read of address 7 returns 0x11BB33DD.
- **Write collision:**
  - Stimulus: s1 writes 0x000000FF with be=4'b0001 and s2 writes 0x0000FF00 with be=4'b0011, both to address 3, starting from 0.
  - Response: address 3 reads 0x0000FFFF; `collision_count` = 1. Saturation is checked by forcing 65536 collisions, after which the count reads 0xFFFF.
- **Cross-port read during write:**
  - Stimulus: address 9 holds 0x1; in one cycle s2 reads address 9 while s1 writes 0x2 to it.
  - Response: s2 returns 0x1; a later read returns 0x2.
- **Latency 2 with clken stall:**
  - Stimulus: READ_LATENCY=2; reads to addresses 0, 1, 2 back-to-back; `clken` dropped for 3 cycles after the second request.
  - Response: exactly three `readdatavalid` beats, in order, and none while `clken`=0.
- **Out-of-range and reset:**
  - Stimulus: write 0x55 to address 342 (DEPTH=342); read address 342; assert `reset` while a read is in flight.
  - Response: the memory is unchanged and the read returns 0. The in-flight read produces no beat, and outputs are 0 while `reset` is high.
